// File: rtl/mem_arb_ctrl_pkg.sv
// mem_arb_ctrl_pkg: shared definitions for the byte-serial memory arbiter.
// Holds FSM state encodings, stall vector constants, mem_len encodings,
// the latched transfer descriptor and small byte-lane helpers.
package mem_arb_ctrl_pkg;

  localparam int unsigned AddrW  = 32;
  localparam int unsigned DataW  = 32;
  localparam int unsigned ByteW  = 8;
  localparam int unsigned CntW   = 2;
  localparam int unsigned LenW   = 2;
  localparam int unsigned StallW = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // mem_len encodings; 2'd3 is treated like LEN_4B
  localparam logic [LenW-1:0] LEN_1B = 2'd0;
  localparam logic [LenW-1:0] LEN_2B = 2'd1;
  localparam logic [LenW-1:0] LEN_4B = 2'd2;

  // Hold vectors: bit i holds pipeline register i (pc, if_id, id_ex, ex_mem, mem_wb)
  localparam logic [StallW-1:0] STALL_NONE = 5'b00000;
  localparam logic [StallW-1:0] STALL_IF   = 5'b00011;
  localparam logic [StallW-1:0] STALL_MEM  = 5'b01111;

  // Transfer descriptor captured in IDLE and held for the whole transfer
  typedef struct packed {
    owner_e              owner;
    logic                we;
    logic [CntW-1:0]     last;
    logic [AddrW-1:0]    base;
    logic [DataW-1:0]    wdata;
  } xfer_t;

  // Index of the final byte for a given length code
  function automatic logic [CntW-1:0] len_last_idx(input logic [LenW-1:0] len);
    logic [CntW-1:0] idx;
    case (len)
      LEN_1B:  idx = 2'd0;
      LEN_2B:  idx = 2'd1;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Little-endian byte lane extract
  function automatic logic [ByteW-1:0] get_byte(input logic [DataW-1:0] word,
                                                input logic [CntW-1:0]  lane);
    return word[{lane, 3'b000} +: ByteW];
  endfunction

  // Little-endian byte lane insert
  function automatic logic [DataW-1:0] put_byte(input logic [DataW-1:0] word,
                                                input logic [CntW-1:0]  lane,
                                                input logic [ByteW-1:0] b);
    logic [DataW-1:0] w;
    w = word;
    w[{lane, 3'b000} +: ByteW] = b;
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: arbitrates an instruction-fetch port (IF) and a load/store
// port (MEM) onto a byte-wide synchronous RAM. Transfers are issued one byte
// per cycle, little-endian; read bytes return the cycle after their address.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request (level, 4 bytes)
//   if_rdata/if_done            fetched word, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_len           load/store request (level), 1/2/4 bytes
//   mem_rdata/mem_done          zero-extended load data, completion pulse
//   ram_addr/ram_wr/ram_dout    RAM byte address, write strobe, write byte
//   ram_din                     RAM read byte (one cycle after ram_addr)
//   stall                       pipeline hold vector (combinational)
//
// Configuration macro MEM_ARB_IF_ABORT_EN: when defined, a MEM request
// arriving during an IF transfer aborts the fetch; the fetch is re-issued
// from byte 0 once MEM has been served.
module mem_arb_ctrl
  import mem_arb_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  // IF side
  input  logic              if_req,
  input  logic [AddrW-1:0]  if_addr,
  output logic [DataW-1:0]  if_rdata,
  output logic              if_done,
  // MEM side
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [AddrW-1:0]  mem_addr,
  input  logic [DataW-1:0]  mem_wdata,
  input  logic [LenW-1:0]   mem_len,
  output logic [DataW-1:0]  mem_rdata,
  output logic              mem_done,
  // RAM side
  output logic [AddrW-1:0]  ram_addr,
  output logic              ram_wr,
  output logic [ByteW-1:0]  ram_dout,
  input  logic [ByteW-1:0]  ram_din,
  // pipeline hold
  output logic [StallW-1:0] stall
);

`ifdef MEM_ARB_IF_ABORT_EN
  localparam bit IfAbortEn = 1'b1;
`else
  localparam bit IfAbortEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  xfer_t             xfer_q, xfer_d;
  logic [DataW-1:0]  data_q, data_d;
  logic              rd_pend_q, rd_pend_d;
  logic [CntW-1:0]   rd_lane_q, rd_lane_d;
  logic [AddrW-1:0]  ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ByteW-1:0]  ram_dout_q, ram_dout_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [DataW-1:0]  if_rdata_q, if_rdata_d;
  logic [DataW-1:0]  mem_rdata_q, mem_rdata_d;
  logic [DataW-1:0]  merged_c;
  logic              abort_c;

  // Data register with the byte returning this cycle folded in
  always_comb begin
    merged_c = data_q;
    if (rd_pend_q) begin
      merged_c = put_byte(data_q, rd_lane_q, ram_din);
    end
  end

  // An IF transfer can only be in flight if mem_req was low when it was
  // latched, so any high mem_req seen during it is a new MEM request.
  always_comb begin
    abort_c = IfAbortEn && (xfer_q.owner == OWN_IF) && mem_req;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    xfer_d      = xfer_q;
    data_d      = merged_c;
    rd_pend_d   = 1'b0;
    rd_lane_d   = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_req || if_req) begin
          // MEM has priority over IF
          if (mem_req) begin
            xfer_d.owner = OWN_MEM;
            xfer_d.we    = mem_we;
            xfer_d.last  = len_last_idx(mem_len);
            xfer_d.base  = mem_addr;
            xfer_d.wdata = mem_wdata;
          end else begin
            xfer_d.owner = OWN_IF;
            xfer_d.we    = 1'b0;
            xfer_d.last  = len_last_idx(LEN_4B);
            xfer_d.base  = if_addr;
            xfer_d.wdata = '0;
          end
          state_d    = ST_XFER;
          cnt_d      = '0;
          data_d     = '0;
          // Byte 0 is presented on the RAM port in the first XFER cycle
          ram_addr_d = xfer_d.base;
          ram_wr_d   = xfer_d.we;
          ram_dout_d = get_byte(xfer_d.wdata, '0);
        end
      end

      ST_XFER: begin
        rd_pend_d = !xfer_q.we;
        rd_lane_d = cnt_q;
        if (abort_c) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          rd_pend_d = 1'b0;
        end else if (cnt_q == xfer_q.last) begin
          // Reads need one more cycle for the final byte to return
          state_d = xfer_q.we ? ST_DONE : ST_LAST;
        end else begin
          cnt_d      = cnt_q + CntW'(1);
          ram_addr_d = xfer_q.base + AddrW'(cnt_d);
          ram_wr_d   = xfer_q.we;
          ram_dout_d = get_byte(xfer_q.wdata, cnt_d);
        end
      end

      ST_LAST: begin
        if (abort_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Completion pulse and result capture coincide with the DONE state
    if (state_d == ST_DONE) begin
      if (xfer_q.owner == OWN_IF) begin
        if_done_d  = 1'b1;
        if_rdata_d = merged_c;
      end else begin
        mem_done_d = 1'b1;
        if (!xfer_q.we) begin
          mem_rdata_d = merged_c;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      xfer_q      <= '0;
      data_q      <= '0;
      rd_pend_q   <= 1'b0;
      rd_lane_q   <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      xfer_q      <= xfer_d;
      data_q      <= data_d;
      rd_pend_q   <= rd_pend_d;
      rd_lane_q   <= rd_lane_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Hold vector follows requests until their done pulse
  always_comb begin
    stall = STALL_NONE;
    if (mem_req && !mem_done_q) begin
      stall = STALL_MEM;
    end else if (if_req && !if_done_q) begin
      stall = STALL_IF;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// tb_mem_arb_ctrl: directed, table-driven bench for mem_arb_ctrl with a
// byte-wide RAM model (read data returned the cycle after the address).
module tb_mem_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_len;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic [4:0]  stall;

  always #5 clk = ~clk;

  mem_arb_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_len   (mem_len),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .ram_addr  (ram_addr),
    .ram_wr    (ram_wr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .stall     (stall)
  );

  // RAM model: 4 KiB aliased over the 32-bit space
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    ram_din <= ram[ram_addr[11:0]];
    if (ram_wr) ram[ram_addr[11:0]] = ram_dout;
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] last_if  = 32'h0;
  logic [31:0] last_mem = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] addr);
    logic [31:0] w;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = addr + 32'(i);
      w[8*i +: 8] = ram[a[11:0]];
    end
    return w;
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = addr + 32'(i);
      ram[a[11:0]] = word[8*i +: 8];
    end
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;   // RAM contents at addr..addr+3 before the transfer
    logic [31:0] exp;    // read: expected rdata; write: expected RAM word after
    int          lat;    // cycles from request sample edge to done pulse
  } vec_t;

  vec_t vecs[10];

  // One transfer: drive at negedge, sample 1 time unit after each posedge
  task automatic run_vec(input int idx, input vec_t v);
    int          n;
    int          lat;
    logic        addr_ok;
    logic        stall_ok;
    logic        other_ok;
    logic [4:0]  exp_stall;
    logic [31:0] a;
    logic [31:0] wd;
    logic        done;
    n         = nbytes(v.len);
    lat       = -1;
    addr_ok   = 1'b1;
    stall_ok  = 1'b1;
    other_ok  = 1'b1;
    wd        = v.wdata;
    exp_stall = v.is_mem ? 5'b01111 : 5'b00011;
    preload(v.addr, v.init);
    @(negedge clk);
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata; mem_len = v.len;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k <= n) begin
        a = v.addr + 32'(k - 1);
        if (ram_addr !== a || ram_wr !== v.we) addr_ok = 1'b0;
        if (v.we && ram_dout !== wd[8*(k-1) +: 8]) addr_ok = 1'b0;
      end else if (ram_wr !== 1'b0) begin
        addr_ok = 1'b0;
      end
      done = v.is_mem ? mem_done : if_done;
      if ((v.is_mem ? if_done : mem_done) !== 1'b0) other_ok = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        if (stall !== 5'b00000) stall_ok = 1'b0;
      end else if (stall !== exp_stall) begin
        stall_ok = 1'b0;
      end
    end
    mem_req = 1'b0;
    if_req  = 1'b0;
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d_ram_port_seq", idx), 32'(addr_ok), 32'd1);
    check($sformatf("v%0d_stall", idx), 32'(stall_ok), 32'd1);
    check($sformatf("v%0d_other_done_quiet", idx), 32'(other_ok), 32'd1);
    if (v.we) begin
      check($sformatf("v%0d_ram_word", idx), ram_word(v.addr), v.exp);
    end else if (v.is_mem) begin
      check($sformatf("v%0d_mem_rdata", idx), mem_rdata, v.exp);
      last_mem = v.exp;
    end else begin
      check($sformatf("v%0d_if_rdata", idx), if_rdata, v.exp);
      last_if = v.exp;
    end
    if (v.is_mem) check($sformatf("v%0d_if_rdata_hold", idx), if_rdata, last_if);
    else          check($sformatf("v%0d_mem_rdata_hold", idx), mem_rdata, last_mem);
    @(posedge clk); #1;
    check($sformatf("v%0d_done_one_cycle", idx), {30'd0, if_done, mem_done}, 32'd0);
  endtask

  int          mem_cyc;
  int          if_cyc;
  int          if_pulses;
  logic [31:0] addr_k5;
  logic [31:0] addr_k8;
  logic [31:0] addr_k9;
  logic [4:0]  stall_k6;
  logic        quiet;

  initial begin
    // 4B IF reads, MEM loads/stores of each length, address wrap
    vecs[0] = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,          32'h4433_2211, 32'h4433_2211, 6};
    vecs[1] = '{1'b1, 1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF,  32'h0000_0000, 32'hDEAD_BEEF, 5};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 32'h0000_03FF, 32'h0,          32'h0000_0080, 32'h0000_0080, 3};
    vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h0000_0010, 32'h1234_56A5,  32'h7777_7777, 32'h7777_77A5, 2};
    vecs[4] = '{1'b1, 1'b0, 2'd1, 32'h0000_0020, 32'h0,          32'h8899_1234, 32'h0000_1234, 4};
    vecs[5] = '{1'b1, 1'b1, 2'd1, 32'h0000_0030, 32'hCAFE_F00D,  32'h5555_5555, 32'h5555_F00D, 3};
    vecs[6] = '{1'b1, 1'b0, 2'd3, 32'h0000_0040, 32'h0,          32'h0403_0201, 32'h0403_0201, 6};
    vecs[7] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,          32'hD4C3_B2A1, 32'hD4C3_B2A1, 6};
    vecs[8] = '{1'b0, 1'b0, 2'd2, 32'h0000_0104, 32'h0,          32'h8D7C_6B5A, 32'h8D7C_6B5A, 6};
    vecs[9] = '{1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0,          32'h0102_0304, 32'h0102_0304, 6};

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_dout", 32'(ram_dout), 32'd0);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_mem_done", 32'(mem_done), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Simultaneous requests: MEM first, IF sampled in the IDLE after mem_done
    preload(32'h100, 32'h4433_2211);
    preload(32'h3FF, 32'h0000_0080);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3FF; mem_len = 2'd0;
    #1;
    check("simul_stall_mem", 32'(stall), 32'b01111);
    mem_cyc = -1; if_cyc = -1; addr_k5 = '0; stall_k6 = '0;
    for (int k = 1; k <= 20 && if_cyc < 0; k++) begin
      @(posedge clk); #1;
      if (mem_done === 1'b1 && mem_cyc < 0) begin mem_cyc = k; mem_req = 1'b0; end
      if (if_done === 1'b1 && if_cyc < 0) begin if_cyc = k; if_req = 1'b0; end
      if (k == 5) addr_k5 = ram_addr;
      if (k == 6) stall_k6 = stall;
    end
    mem_req = 1'b0; if_req = 1'b0;
    check("simul_mem_done_cycle", 32'(mem_cyc), 32'd3);
    check("simul_if_done_cycle", 32'(if_cyc), 32'd10);
    check("simul_if_first_addr", addr_k5, 32'h100);
    check("simul_stall_if", 32'(stall_k6), 32'b00011);
    check("simul_mem_rdata", mem_rdata, 32'h80);
    check("simul_if_rdata", if_rdata, 32'h4433_2211);
    @(posedge clk); #1;

    // MEM request arriving while IF byte 2 is on the RAM port
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    mem_cyc = -1; if_cyc = -1; if_pulses = 0; addr_k8 = '0; addr_k9 = '0;
    for (int k = 1; k <= 30 && (mem_cyc < 0 || if_cyc < 0); k++) begin
      @(posedge clk); #1;
      if (k == 3) begin
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3FF; mem_len = 2'd0;
      end
      if (k == 8) addr_k8 = ram_addr;
      if (k == 9) addr_k9 = ram_addr;
      if (if_done === 1'b1) if_pulses++;
      if (mem_done === 1'b1 && mem_cyc < 0) begin mem_cyc = k; mem_req = 1'b0; end
      if (if_done === 1'b1 && if_cyc < 0) begin if_cyc = k; if_req = 1'b0; end
    end
    mem_req = 1'b0; if_req = 1'b0;
`ifdef MEM_ARB_IF_ABORT_EN
    check("abort_mem_done_cycle", 32'(mem_cyc), 32'd7);
    check("abort_if_done_cycle", 32'(if_cyc), 32'd14);
    check("abort_refetch_addr", addr_k9, 32'h100);
`else
    check("noabort_if_done_cycle", 32'(if_cyc), 32'd6);
    check("noabort_mem_done_cycle", 32'(mem_cyc), 32'd10);
    check("noabort_mem_addr", addr_k8, 32'h3FF);
`endif
    check("abort_if_pulses", 32'(if_pulses), 32'd1);
    check("abort_if_rdata", if_rdata, 32'h4433_2211);
    @(posedge clk); #1;

    // Reset during the second XFER cycle of a 4B store
    preload(32'h280, 32'h0000_0000);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h280; mem_wdata = 32'h1122_3344; mem_len = 2'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_mid_ram_addr", ram_addr, 32'd0);
    check("rst_mid_mem_done", 32'(mem_done), 32'd0);
    check("rst_mid_if_rdata", if_rdata, 32'd0);
    check("rst_mid_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0; mem_req = 1'b0;
    quiet = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (mem_done !== 1'b0 || if_done !== 1'b0 || ram_wr !== 1'b0) quiet = 1'b0;
    end
    check("rst_mid_no_done", 32'(quiet), 32'd1);
    check("rst_mid_ram_word", ram_word(32'h280), 32'h0000_3344);
    last_if = 32'h0; last_mem = 32'h0;

    // Controller resumes normally from IDLE
    run_vec(10, vecs[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have IF-side ports: if_req  in  1  fetch request (level); if_addr  in  32  fetch byte address; if_rdata  out  32  fetched word; if_done  out  1  one-cycle completion pulse.
REQ-003 SHALL have MEM-side ports: mem_req  in  1  load/store request (level); mem_we  in  1  1=store; mem_addr  in  32  byte address; mem_wdata  in  32  store data; mem_len  in  2  0=1B, 1=2B, 2 or 3=4B; mem_rdata  out  32  load data, zero-extended; mem_done  out  1  one-cycle completion pulse.
REQ-004 SHALL have RAM-side ports: ram_addr  out  32  byte address; ram_wr  out  1  write strobe; ram_dout  out  8  write byte; ram_din  in  8  read byte, valid the cycle after ram_addr.
REQ-005 SHALL have port stall  out  5  pipeline hold vector; bit i holds stage register i (0=pc, 1=if_id, 2=id_ex, 3=ex_mem, 4=mem_wb).

Function
REQ-006 SHALL implement FSM states IDLE, XFER, LAST (read drain), DONE.
REQ-007 IDLE: on mem_req SHALL latch MEM request, owner=MEM; else on if_req latch IF request (len=4B), owner=IF; next state XFER, byte counter cnt=0.
REQ-008 XFER: SHALL drive ram_addr=base+cnt, ram_wr=we, ram_dout=wdata byte cnt (little-endian); cnt increments each cycle.
REQ-009 Read byte cnt SHALL be captured from ram_din the following cycle into byte lane cnt of the data register.
REQ-010 After the last byte is issued: writes SHALL go to DONE; reads SHALL go to LAST for one cycle to capture the final byte, then DONE.
REQ-011 DONE: SHALL pulse if_done or mem_done (per owner) for exactly one cycle with if_rdata/mem_rdata valid, then return to IDLE.
REQ-012 Latency from request sample to done pulse: 4B read 6 cycles, 4B write 5 cycles, 1B read 3 cycles, 1B write 2 cycles.
REQ-013 if_rdata and mem_rdata SHALL hold their last completed value until the next completion of that owner.
REQ-014 ram_wr SHALL be 0 in every state other than XFER.
REQ-015 Address arithmetic SHALL wrap modulo 2^32; no alignment check.
REQ-016 stall SHALL be 5'b01111 whenever mem_req=1 and mem_done=0; else 5'b00011 whenever if_req=1 and if_done=0; else 5'b00000.
REQ-017 Simultaneous mem_req and if_req in IDLE: MEM SHALL win; IF is served on a later IDLE.
REQ-018 Requesters SHALL hold req and operands stable until their done pulse; the block samples operands only in IDLE.

Reset
REQ-019 rst SHALL force state=IDLE, cnt=0, ram_wr=0, ram_addr=0, ram_dout=0, if_done=0, mem_done=0, if_rdata=0, mem_rdata=0; stall then follows REQ-016 combinationally.
REQ-020 rst mid-transfer SHALL abandon the transfer with no done pulse; next cycle IDLE.

Configuration
REQ-021 Macro MEM_ARB_IF_ABORT_EN: when defined, mem_req rising during an IF-owned XFER/LAST SHALL abort the fetch (no if_done, no further ram_wr/addr from it) and enter IDLE the next cycle, serving MEM; the fetch restarts from byte 0 afterwards.
REQ-022 Without MEM_ARB_IF_ABORT_EN, an IF transfer in progress SHALL always complete before MEM is accepted.

Structure
REQ-023 Shared defines file SHALL hold state encodings, stall vector constants (STALL_NONE, STALL_IF, STALL_MEM), and mem_len encodings.
REQ-024 Single module; no sub-module required.

Verification
REQ-025 IF read, if_addr=0x100, RAM[0x100..0x103]=11,22,33,44 -> ram_addr 0x100..0x103 consecutive, if_done cycle 6, if_rdata=0x44332211, stall=00011 until done.
REQ-026 MEM 4B store, addr=0x200, wdata=0xDEADBEEF -> ram_wr 4 cycles, bytes EF,BE,AD,DE at 0x200..0x203, mem_done cycle 5, stall=01111.
REQ-027 MEM 1B load, addr=0x3FF, RAM=0x80 -> mem_rdata=0x00000080, mem_done cycle 3.
REQ-028 if_req and mem_req asserted same cycle -> MEM transfer first, IF starts in IDLE after mem_done.
REQ-029 rst asserted in 2nd XFER cycle of a store -> ram_wr=0 next cycle, no done pulse, state IDLE.
REQ-030 With MEM_ARB_IF_ABORT_EN: mem_req at IF byte 2 -> no if_done, MEM served, fetch then re-issued from if_addr+0; without macro, if_done precedes MEM start.
